// File: rtl/viterbi_ber_checker.sv
// rtl/viterbi_ber_checker.sv - Viterbi loopback BER monitor with automatic latency search and lock tracking.
module viterbi_ber_checker #(
  parameter int MAX_LAT  = 64,
  parameter int WIN      = 32,
  parameter int LOCK_ERR = 2,
  parameter int LOSS_ERR = 8,
  parameter int CW       = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ref_valid_i,
  input  logic                       ref_i,
  input  logic                       dec_valid_i,
  input  logic                       dec_i,
  output logic                       locked_o,
  output logic [$clog2(MAX_LAT)-1:0] lat_o,
  output logic [CW-1:0]              bit_ct_o,
  output logic [CW-1:0]              err_ct_o,
  output logic                       err_o,
  output logic [15:0]                unlock_ct_o
);

  localparam int LW  = $clog2(MAX_LAT);
  localparam int FW  = $clog2(MAX_LAT + 1);
  localparam int WCW = $clog2(WIN);
  localparam int WEW = $clog2(WIN + 1);
  localparam logic [FW-1:0]  FILL_MAX = FW'(MAX_LAT);
  localparam logic [WCW-1:0] WIN_LAST = WCW'(WIN - 1);
  localparam logic [WEW-1:0] LOCK_TH  = WEW'(LOCK_ERR);
  localparam logic [WEW-1:0] LOSS_TH  = WEW'(LOSS_ERR);

  typedef enum logic {S_SEARCH, S_LOCKED} state_t;

  state_t             state_q, state_d;
  logic [MAX_LAT-1:0] hist_q, hist_d;
  logic [FW-1:0]      fill_q, fill_d;
  logic [LW-1:0]      cand_q, cand_d;
  logic [LW-1:0]      lat_q, lat_d;
  logic [WCW-1:0]     win_cnt_q, win_cnt_d;
  logic [WEW-1:0]     win_err_q, win_err_d;
  logic [CW-1:0]      bit_ct_q, bit_ct_d;
  logic [CW-1:0]      err_ct_q, err_ct_d;
  logic [15:0]        unlock_q, unlock_d;
  logic               err_q, err_d;

  logic               mis;
  logic               counted;
  logic               last;
  logic [WEW-1:0]     total;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_SEARCH;
      hist_q    <= '0;
      fill_q    <= '0;
      cand_q    <= '0;
      lat_q     <= '0;
      win_cnt_q <= '0;
      win_err_q <= '0;
      bit_ct_q  <= '0;
      err_ct_q  <= '0;
      unlock_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      cand_q    <= cand_d;
      lat_q     <= lat_d;
      win_cnt_q <= win_cnt_d;
      win_err_q <= win_err_d;
      bit_ct_q  <= bit_ct_d;
      err_ct_q  <= err_ct_d;
      unlock_q  <= unlock_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    cand_d    = cand_q;
    lat_d     = lat_q;
    win_cnt_d = win_cnt_q;
    win_err_d = win_err_q;
    bit_ct_d  = bit_ct_q;
    err_ct_d  = err_ct_q;
    unlock_d  = unlock_q;
    err_d     = 1'b0;

    // Compare against the pre-shift history so a same-cycle ref strobe cannot skew the delay.
    mis     = dec_i ^ hist_q[cand_q];
    counted = dec_valid_i && (fill_q > FW'(cand_q));
    last    = (win_cnt_q == WIN_LAST);
    total   = win_err_q + WEW'(mis);

    if (ref_valid_i) begin
      hist_d = {hist_q[MAX_LAT-2:0], ref_i};
      if (fill_q != FILL_MAX) fill_d = fill_q + 1'b1;
    end

    if (counted) begin
      if (last) begin
        win_cnt_d = '0;
        win_err_d = '0;
      end else begin
        win_cnt_d = win_cnt_q + 1'b1;
        win_err_d = total;
      end

      case (state_q)
        S_SEARCH: begin
          if (last) begin
            if (total <= LOCK_TH) begin
              state_d = S_LOCKED;
              lat_d   = cand_q;
            end else begin
              cand_d = cand_q + 1'b1;
            end
          end
        end
        S_LOCKED: begin
          if (bit_ct_q != '1) bit_ct_d = bit_ct_q + 1'b1;
          if (mis) begin
            err_d = 1'b1;
            if (err_ct_q != '1) err_ct_d = err_ct_q + 1'b1;
          end
          if (last && (total > LOSS_TH)) begin
            state_d = S_SEARCH;
            cand_d  = '0;
            if (unlock_q != '1) unlock_d = unlock_q + 1'b1;
          end
        end
        default: state_d = S_SEARCH;
      endcase
    end
  end

  assign locked_o    = (state_q == S_LOCKED);
  assign lat_o       = lat_q;
  assign bit_ct_o    = bit_ct_q;
  assign err_ct_o    = err_ct_q;
  assign err_o       = err_q;
  assign unlock_ct_o = unlock_q;

endmodule

// File: tb/tb_viterbi_ber_checker.sv
// tb/tb_viterbi_ber_checker.sv - Randomized bench for viterbi_ber_checker against a window-level reference model.
module tb_viterbi_ber_checker;

  localparam int MAX_LAT  = 64;
  localparam int WIN      = 32;
  localparam int LOCK_ERR = 2;
  localparam int LOSS_ERR = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ref_valid_i = 1'b0, ref_i = 1'b0, dec_valid_i = 1'b0, dec_i = 1'b0;

  logic        locked_o, err_o;
  logic [5:0]  lat_o;
  logic [31:0] bit_ct_o, err_ct_o;
  logic [15:0] unlock_ct_o;

  logic        locked4, err4;
  logic [5:0]  lat4;
  logic [3:0]  bit4, errc4;
  logic [15:0] unlock4;

  always #5 clk = ~clk;

  viterbi_ber_checker #(.MAX_LAT(MAX_LAT), .WIN(WIN), .LOCK_ERR(LOCK_ERR), .LOSS_ERR(LOSS_ERR), .CW(32)) dut (
    .clk(clk), .rst(rst), .ref_valid_i(ref_valid_i), .ref_i(ref_i),
    .dec_valid_i(dec_valid_i), .dec_i(dec_i), .locked_o(locked_o), .lat_o(lat_o),
    .bit_ct_o(bit_ct_o), .err_ct_o(err_ct_o), .err_o(err_o), .unlock_ct_o(unlock_ct_o));

  viterbi_ber_checker #(.MAX_LAT(MAX_LAT), .WIN(WIN), .LOCK_ERR(LOCK_ERR), .LOSS_ERR(LOSS_ERR), .CW(4)) dut4 (
    .clk(clk), .rst(rst), .ref_valid_i(ref_valid_i), .ref_i(ref_i),
    .dec_valid_i(dec_valid_i), .dec_i(dec_i), .locked_o(locked4), .lat_o(lat4),
    .bit_ct_o(bit4), .err_ct_o(errc4), .err_o(err4), .unlock_ct_o(unlock4));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: reference stream as a queue (index k = k-th newest bit), window tallies as integers.
  bit      ref_hist[$];
  bit      m_locked, m_erro;
  int      m_cand, m_lat, m_wcnt, m_werr;
  longint  m_bit, m_err, m_unl;

  function automatic longint sat(input longint v, input int w);
    longint mx = (longint'(1) << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  function automatic bit delayed(input int k);
    return (ref_hist.size() > k) ? ref_hist[k] : 1'b0;
  endfunction

  task automatic model_step(input bit r_rst, input bit rv, input bit r, input bit dv, input bit d);
    bit mis;
    if (r_rst) begin
      ref_hist.delete();
      m_locked = 0; m_erro = 0; m_cand = 0; m_lat = 0; m_wcnt = 0; m_werr = 0;
      m_bit = 0; m_err = 0; m_unl = 0;
      return;
    end
    m_erro = 0;
    if (dv && ref_hist.size() > m_cand) begin
      mis = d ^ ref_hist[m_cand];
      m_wcnt++;
      m_werr += int'(mis);
      if (m_locked) begin
        m_bit++;
        if (mis) begin m_err++; m_erro = 1; end
      end
      if (m_wcnt == WIN) begin
        if (!m_locked) begin
          if (m_werr <= LOCK_ERR) begin m_locked = 1; m_lat = m_cand; end
          else m_cand = (m_cand + 1) % MAX_LAT;
        end else if (m_werr > LOSS_ERR) begin
          m_locked = 0; m_cand = 0; m_unl++;
        end
        m_wcnt = 0; m_werr = 0;
      end
    end
    if (rv) begin
      ref_hist.push_front(r);
      if (ref_hist.size() > MAX_LAT) void'(ref_hist.pop_back());
    end
  endtask

  task automatic check_all();
    check("locked", locked_o, m_locked);
    check("lat", lat_o, m_lat);
    check("bit_ct", bit_ct_o, sat(m_bit, 32));
    check("err_ct", err_ct_o, sat(m_err, 32));
    check("err_o", err_o, m_erro);
    check("unlock_ct", unlock_ct_o, sat(m_unl, 16));
    check("locked4", locked4, m_locked);
    check("bit_ct4", bit4, sat(m_bit, 4));
    check("err_ct4", errc4, sat(m_err, 4));
    check("err_o4", err4, m_erro);
  endtask

  task automatic cycle(input bit rv, input bit r, input bit dv, input bit d);
    ref_valid_i = rv; ref_i = r; dec_valid_i = dv; dec_i = d;
    @(posedge clk);
    model_step(rst, rv, r, dv, d);
    @(negedge clk);
    check_all();
  endtask

  logic [15:0] lfsr = 16'hACE1;
  task automatic lfsr_step();
    lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  endtask

  initial begin
    int n;
    longint saved;
    bit rv, dv;

    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 2; i++) cycle($urandom_range(1), $urandom_range(1), $urandom_range(1), $urandom_range(1));
    check("rst_locked", locked_o, 1'b0);
    check("rst_bit_ct", bit_ct_o, 32'd0);
    check("rst_unlock", unlock_ct_o, 16'd0);
    rst = 1'b0;

    // Clean lock at delay 5: candidates 0..4 fail, lock after the 192nd counted compare.
    n = 0;
    while (!locked_o && n < 400) begin
      cycle(1, lfsr[0], 1, delayed(5));
      lfsr_step();
      n++;
      if (n == 32) check("early_unlocked", locked_o, 1'b0);
    end
    check("lock_cycles", n, 193);
    check("lock_lat", lat_o, 6'd5);
    check("lock_err_ct", err_ct_o, 32'd0);

    saved = m_bit;
    for (int k = 0; k < 64; k++) begin
      cycle(1, lfsr[0], 1, delayed(5));
      lfsr_step();
    end
    check("clean_bits", bit_ct_o, 32'(saved + 64));

    saved = err_ct_o;
    for (int k = 0; k < 128; k++) begin
      cycle(1, lfsr[0], 1, delayed(5) ^ (k % 16 == 15));
      lfsr_step();
    end
    check("sparse_errs", err_ct_o, 32'(saved + 8));
    check("sparse_locked", locked_o, 1'b1);

    // Loss and relock at delay 9.
    n = 0;
    while (locked_o && n < 100) begin
      cycle(1, lfsr[0], 1, delayed(9));
      lfsr_step();
      n++;
    end
    check("loss_locked", locked_o, 1'b0);
    check("loss_unlock", unlock_ct_o, 16'd1);
    saved = err_ct_o;
    n = 0;
    while (!locked_o && n < 2000) begin
      cycle(1, lfsr[0], 1, delayed(9));
      lfsr_step();
      n++;
    end
    check("relock_locked", locked_o, 1'b1);
    check("relock_lat", lat_o, 6'd9);
    check("relock_err_kept", err_ct_o, 32'(saved));

    // Independent 50% valid gaps: delay counted in reference strobes.
    rst = 1'b1;
    cycle(1, 1, 1, 1);
    rst = 1'b0;
    n = 0;
    while (!locked_o && n < 4000) begin
      rv = 1'($urandom_range(1));
      dv = 1'($urandom_range(1));
      cycle(rv, lfsr[0], dv, dv ? delayed(5) : 1'($urandom_range(1)));
      if (rv) lfsr_step();
      n++;
    end
    check("gap_locked", locked_o, 1'b1);
    check("gap_lat", lat_o, 6'd5);
    saved = bit_ct_o;
    for (int k = 0; k < 40; k++) begin
      rv = 1'($urandom_range(1));
      cycle(rv, lfsr[0], 0, 1'($urandom_range(1)));
      if (rv) lfsr_step();
    end
    check("gap_no_dv_bits", bit_ct_o, 32'(saved));

    // Eight errors per window keep lock while driving the 4-bit counters into saturation.
    for (int k = 0; k < 96; k++) begin
      cycle(1, lfsr[0], 1, delayed(5) ^ (k % 4 == 0));
      lfsr_step();
    end
    check("sat_locked", locked_o, 1'b1);
    check("sat_bit4", bit4, 4'd15);
    check("sat_err4", errc4, 4'd15);
    check("sat_err32", err_ct_o, 32'd24);
    check("sat_bit32", bit_ct_o, 32'(saved + 96));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/viterbi_ber_checker.md
# viterbi_ber_checker

Receive-side bit-error-rate monitor for the convolutional-encoder / channel / Viterbi-decoder loopback. It records the bit stream presented to the encoder and finds the end-to-end latency of the decoded stream automatically. After locking to that latency, it counts decoded bits and bit errors and reports loss of lock. It sits beside the decoder output in the loopback harness and replaces manual error bookkeeping in simulation.

## Interface
Parameters:
- MAX_LAT, 64: number of candidate latencies (0..MAX_LAT-1) and depth of the reference history. Must be a power of 2 and at least 2.
- WIN, 32: compares per evaluation window.
- LOCK_ERR, 2: maximum window errors allowed to declare lock.
- LOSS_ERR, 8: window errors above this value drop lock.
- CW, 32: width of the bit and error counters.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- ref_valid_i  in  1  reference bit strobe (encoder input enable).
- ref_i  in  1  reference bit (encoder input).
- dec_valid_i  in  1  decoded bit strobe.
- dec_i  in  1  decoded bit (decoder output).
- locked_o  out  1  latency lock achieved.
- lat_o  out  $clog2(MAX_LAT)  locked latency; holds the last locked value while searching.
- bit_ct_o  out  CW  compares made while locked.
- err_ct_o  out  CW  mismatches counted while locked.
- err_o  out  1  one-cycle pulse for each locked mismatch.
- unlock_ct_o  out  16  number of LOCKED-to-SEARCH transitions.

## Operation
- **History register.** hist[MAX_LAT-1:0] captures the reference stream. On ref_valid_i: hist <= {hist[MAX_LAT-2:0], ref_i}, so hist[0] is the newest bit. A fill counter increments on ref_valid_i and saturates at MAX_LAT.
- **Compare.** On dec_valid_i, the block computes mis = dec_i ^ hist[cand], using the register value *before* any same-cycle shift. Simultaneous ref_valid_i and dec_valid_i are legal and expected.
- **Ignored compares.** A compare with fill <= cand is ignored: no window count, no error count.
- **Window counters.**
  - win_cnt runs 0..WIN-1 and increments per counted compare.
  - win_err accumulates mis over the window.
  - At the WIN-th compare, the window is evaluated using the total that includes this compare. Both counters then clear.
- **State machine (two states, reset to SEARCH with cand=0).**
  - SEARCH, window total <= LOCK_ERR: go to LOCKED, lat_o <= cand.
  - SEARCH, window total > LOCK_ERR: cand <= cand+1, wrapping MAX_LAT-1 -> 0. Stay in SEARCH.
  - LOCKED, each counted compare: bit_ct_o += 1; if mis, err_ct_o += 1 and err_o pulses.
  - LOCKED, window total > LOSS_ERR: go to SEARCH, cand <= 0, unlock_ct_o += 1.
  - The compare that closes a losing window is still counted in bit_ct_o and err_ct_o.
- **Counter widths.** bit_ct_o, err_ct_o and unlock_ct_o saturate at all-ones and never wrap. Counters are not cleared on relock; only rst clears them.
- **Window width.** win_err needs $clog2(WIN+1) bits.

## Timing
- All outputs are registered. The effect of a compare on dec_valid_i in cycle t is visible in cycle t+1: counters, err_o and the locked_o transition all appear at t+1.
- err_o is high for exactly one cycle per locked mismatch. Back-to-back valid mismatches give a continuous high.
- **Reset values:** locked_o=0, lat_o=0, bit_ct_o=0, err_ct_o=0, err_o=0, unlock_ct_o=0. hist, fill, cand, win_cnt and win_err are also 0.
- **Reset mid-operation:** rst takes priority over all inputs. State returns to SEARCH on the next edge, and inputs in that cycle are ignored.
- **Latency from first lock attempt:** the earliest lock is at WIN counted compares after fill > cand. The worst-case search is MAX_LAT windows.

## Test plan
- **Reset:** drive rst=1 for 2 cycles with random inputs -> every output is 0, and locked_o stays 0 for the first 31 compares.
- **Clean lock at latency 5:** ref from a fixed-seed 16-bit LFSR on every cycle; dec_i = ref delayed so that it equals hist[5]; both valids high.
  - Expected: candidates 0-4 fail; locked_o rises one cycle after the 192nd counted compare.
  - lat_o=5, err_ct_o=0; bit_ct_o increments by 1 per cycle after lock.
- **Sparse errors while locked:** invert dec_i on every 16th compare -> err_o pulses once per 16 cycles, err_ct_o = bit_ct_o/16, and locked_o stays 1 (2 errors per window <= LOSS_ERR).
- **Loss and relock:** switch the delay to 9 while locked.
  - Expected: the first window with more than 8 errors drops locked_o, and unlock_ct_o=1.
  - The search restarts at cand 0 and relocks with lat_o=9; err_ct_o is retained.
- **Valid gaps:** toggle dec_valid_i and ref_valid_i independently at 50% -> lock still occurs at lat_o=5 (delay counted in strobes), and counters advance only on dec_valid_i.
- **Saturation:** with CW=4, run 40 locked compares, all mismatching after lock is forced by pre-loading clean data -> bit_ct_o and err_ct_o hold at 15 with no wrap.
